// File: rtl/seq_chunk_adder_if.sv
// +----------------------------------------------------------------------+
// | seq_chunk_adder_if : operand/result handshake bus for seq_chunk_adder |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

`default_nettype wire

// File: rtl/seq_chunk_adder.sv
// +----------------------------------------------------------------------+
// | seq_chunk_adder : multi-cycle add/subtract, CHUNK bits per clock      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_chunk_adder_if.slave   bus
);

  localparam int N      = WIDTH / CHUNK;
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int BASE_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [BASE_W-1:0]  base;
  logic [CHUNK:0]     chunk_sum;
  logic [WIDTH-1:0]   res_next;

  // Subtraction is folded in at accept time: b is inverted and the borrow-in
  // becomes a carry-in, so the datapath below is a plain adder.
  always_comb begin
    base      = BASE_W'(int'(idx_q) * CHUNK);
    chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    res_next  = res_q;
    res_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.cin ^ bus.sub;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d   = res_next;
        carry_d = chunk_sum[CHUNK];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N - 1)) begin
          state_d = DONE;
          sum_d   = res_next;
          cout_d  = chunk_sum[CHUNK];
          // carry into the MSB is recovered from the MSB sum bit and operands
          ovf_d   = chunk_sum[CHUNK] ^ res_next[WIDTH-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1];
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
// +----------------------------------------------------------------------+
// | tb_seq_chunk_adder : CHUNK = 4, 16 and 1 instances, queue scoreboard  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_seq_chunk_adder;

  logic clk;
  logic rst_n;

  logic        in_valid_s  [3];
  logic [15:0] a_s         [3];
  logic [15:0] b_s         [3];
  logic        cin_s       [3];
  logic        sub_s       [3];
  logic        out_ready_s [3];

  logic [2:0]  in_ready_w;
  logic [2:0]  out_valid_w;
  logic [2:0]  cout_w;
  logic [2:0]  ovf_w;
  logic [15:0] sum_w [3];

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
    seq_chunk_adder_if #(.WIDTH(16)) ifc ();
    seq_chunk_adder #(.WIDTH(16), .CHUNK(CH)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
    );
    assign ifc.in_valid  = in_valid_s[g];
    assign ifc.a         = a_s[g];
    assign ifc.b         = b_s[g];
    assign ifc.cin       = cin_s[g];
    assign ifc.sub       = sub_s[g];
    assign ifc.out_ready = out_ready_s[g];
    assign in_ready_w[g]  = ifc.in_ready;
    assign out_valid_w[g] = ifc.out_valid;
    assign sum_w[g]       = ifc.sum;
    assign cout_w[g]      = ifc.cout;
    assign ovf_w[g]       = ifc.overflow;
  end

  function automatic int lat_of(input int cfg);
    return (cfg == 0) ? 5 : ((cfg == 1) ? 2 : 17);
  endfunction

  // Reference: {overflow, cout, sum}; subtract uses real subtraction, cout = no borrow.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [16:0] full;
    logic        c;
    logic        ovf;
    if (sub) begin
      full = {1'b0, a} - {1'b0, b} - {16'd0, cin};
      c    = ~full[16];
      ovf  = (a[15] != b[15]) && (full[15] != a[15]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      c    = full[16];
      ovf  = (a[15] == b[15]) && (full[15] != a[15]);
    end
    return {ovf, c, full[15:0]};
  endfunction

  task automatic start_op(input int cfg, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [17:0] exp);
    @(negedge clk);
    a_s[cfg] = a; b_s[cfg] = b; cin_s[cfg] = cin; sub_s[cfg] = sub;
    in_valid_s[cfg] = 1'b1;
    checks++;
    if (in_ready_w[cfg] !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_before_accept cfg%0d: got %b expected 1", cfg, in_ready_w[cfg]);
    end
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    in_valid_s[cfg] = 1'b0;
  endtask

  task automatic wait_result(input int cfg);
    int edges;
    logic [17:0] exp;
    edges = 1;
    while (out_valid_w[cfg] !== 1'b1 && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checks++;
    if (edges != lat_of(cfg)) begin
      errors++;
      $display("FAIL latency cfg%0d: got %0d edges expected %0d", cfg, edges, lat_of(cfg));
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 18'h3FFFF;
    checks++;
    if ({ovf_w[cfg], cout_w[cfg], sum_w[cfg]} !== exp) begin
      errors++;
      $display("FAIL result cfg%0d: got ovf/cout/sum %h expected %h", cfg,
               {ovf_w[cfg], cout_w[cfg], sum_w[cfg]}, exp);
    end
  endtask

  task automatic test_reset;
    #2;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready_w[c] !== 1'b1 || out_valid_w[c] !== 1'b0 ||
          {ovf_w[c], cout_w[c], sum_w[c]} !== 18'h0) begin
        errors++;
        $display("FAIL reset_state cfg%0d: got rdy=%b vld=%b res=%h expected rdy=1 vld=0 res=0",
                 c, in_ready_w[c], out_valid_w[c], {ovf_w[c], cout_w[c], sum_w[c]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    start_op(0, 16'h0001, 16'h0000, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0001});
    wait_result(0);
  endtask

  task automatic test_carry;
    for (int c = 0; c < 3; c++) begin
      start_op(c, 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000}); wait_result(c);
      start_op(c, 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000}); wait_result(c);
      start_op(c, 16'h000A, 16'h0003, 1'b1, 1'b0, {1'b0, 1'b0, 16'h000E}); wait_result(c);
    end
  endtask

  task automatic test_subtract;
    for (int c = 0; c < 3; c++) begin
      start_op(c, 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE}); wait_result(c);
      start_op(c, 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}); wait_result(c);
      start_op(c, 16'h0010, 16'h0001, 1'b1, 1'b1, {1'b0, 1'b1, 16'h000E}); wait_result(c);
    end
  endtask

  task automatic test_backpressure;
    logic [17:0] hold;
    hold = {1'b0, 1'b0, 16'h5555};
    out_ready_s[0] = 1'b0;
    start_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, hold);
    wait_result(0);
    for (int i = 0; i < 10; i++) begin
      in_valid_s[0] = 1'b1;
      a_s[0] = 16'($urandom); b_s[0] = 16'($urandom);
      cin_s[0] = 1'($urandom); sub_s[0] = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ovf_w[0], cout_w[0], sum_w[0]} !== hold || in_ready_w[0] !== 1'b0 ||
          out_valid_w[0] !== 1'b1) begin
        errors++;
        $display("FAIL hold cycle %0d: got res=%h rdy=%b vld=%b expected res=%h rdy=0 vld=1",
                 i, {ovf_w[0], cout_w[0], sum_w[0]}, in_ready_w[0], out_valid_w[0], hold);
      end
    end
    a_s[0] = 16'h0100; b_s[0] = 16'h0022; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
    out_ready_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready_w[0] !== 1'b1 || out_valid_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL release_to_idle: got rdy=%b vld=%b expected rdy=1 vld=0",
               in_ready_w[0], out_valid_w[0]);
    end
    exp_q.push_back({1'b0, 1'b0, 16'h0122});
    @(posedge clk);
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    checks++;
    if (in_ready_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL accept_after_release: got rdy=%b expected 0", in_ready_w[0]);
    end
    wait_result(0);
  endtask

  task automatic test_reset_mid;
    logic seen;
    start_op(0, 16'hAAAA, 16'h1111, 1'b0, 1'b0, 18'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    checks++;
    if (in_ready_w[0] !== 1'b1 || out_valid_w[0] !== 1'b0 ||
        {ovf_w[0], cout_w[0], sum_w[0]} !== 18'h0) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b vld=%b res=%h expected rdy=1 vld=0 res=0",
               in_ready_w[0], out_valid_w[0], {ovf_w[0], cout_w[0], sum_w[0]});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid_w[0] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL aborted_op_delivered: got out_valid seen=%b expected 0", seen);
    end
    start_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2345});
    wait_result(0);
  endtask

  task automatic test_sweep;
    logic [15:0] a, b;
    logic        cin, sub;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < ((c == 0) ? 200 : 1000); i++) begin
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        start_op(c, a, b, cin, sub, model(a, b, cin, sub));
        wait_result(c);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid_s[c] = 1'b0; a_s[c] = '0; b_s[c] = '0;
      cin_s[c] = 1'b0; sub_s[c] = 1'b0; out_ready_s[c] = 1'b1;
    end
    test_reset;
    test_basic;
    test_carry;
    test_subtract;
    test_backpressure;
    test_reset_mid;
    test_sweep;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
